datapath_fsm_ctrl: RTL and testbench

//  Moore FSM controller that sequences the Simple RISC Machine datapath: register file, loada/loadb/loadc

---
 rtl/datapath_fsm_ctrl_pkg.sv | 84 ++++++++
 rtl/datapath_fsm_ctrl_outdec.sv | 56 +++++
 rtl/datapath_fsm_ctrl.sv | 98 +++++++++
 tb/tb_datapath_fsm_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_fsm_ctrl_pkg.sv
// Shared types and constants for the datapath sequencing controller.
// Optional illegal-opcode trap: DATAPATH_FSM_ILLEGAL_TRAP_EN.
package datapath_fsm_ctrl_pkg;

  localparam int STATE_BITS = 3;

  typedef enum logic [STATE_BITS-1:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_GET_A  = 3'd2,
    S_GET_B  = 3'd3,
    S_EXEC   = 3'd4,
    S_WR_REG = 3'd5,
    S_WR_IMM = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b100;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM   = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  typedef struct packed {
    logic       w;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       asel;
    logic       bsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       write;
    logic       err;
  } ctrl_t;

  function automatic logic is_mov_imm(
    input logic [4:0] lop
  );
    return lop == {OPC_MOV, OP_MOV_IMM};
  endfunction

  function automatic logic is_mov_reg(
    input logic [4:0] lop
  );
    return lop == {OPC_MOV, OP_MOV_REG};
  endfunction

  function automatic logic is_alu(
    input logic [4:0] lop
  );
    return lop[4:2] == OPC_ALU;
  endfunction

  function automatic logic is_cmp(
    input logic [4:0] lop
  );
    return lop == {OPC_ALU, OP_CMP};
  endfunction

  // MOV reg and MVN both pass B through with A forced to zero
  function automatic logic a_zero(
    input logic [4:0] lop
  );
    return is_mov_reg(lop) ||
           (lop == {OPC_ALU, OP_MVN});
  endfunction

endpackage

// File: rtl/datapath_fsm_ctrl_outdec.sv
// Moore output decode of {state, latched instruction}.
// err is only driven with DATAPATH_FSM_ILLEGAL_TRAP_EN.
module datapath_fsm_ctrl_outdec
  import datapath_fsm_ctrl_pkg::*;
(
  input  state_t     st,
  input  logic [4:0] lop,
  input  logic       reset,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (st)
      S_WAIT: ctrl.w = 1'b1;
      S_GET_A: begin
        ctrl.nsel  = NSEL_RN;
        ctrl.loada = 1'b1;
      end
      S_GET_B: begin
        ctrl.nsel  = NSEL_RM;
        ctrl.loadb = 1'b1;
      end
      S_EXEC: begin
        ctrl.asel = a_zero(lop);
        if (is_cmp(lop))
          ctrl.loads = 1'b1;
        else
          ctrl.loadc = 1'b1;
      end
      S_WR_REG: begin
        ctrl.nsel  = NSEL_RD;
        ctrl.vsel  = VSEL_C;
        ctrl.write = 1'b1;
      end
      S_WR_IMM: begin
        ctrl.nsel  = NSEL_RN;
        ctrl.vsel  = VSEL_IMM;
        ctrl.write = 1'b1;
      end
`ifdef DATAPATH_FSM_ILLEGAL_TRAP_EN
      S_ERR: ctrl.err = 1'b1;
`endif
      default: ;
    endcase
    // no datapath side effect may happen in a reset cycle
    if (reset) begin
      ctrl.loada = 1'b0;
      ctrl.loadb = 1'b0;
      ctrl.loadc = 1'b0;
      ctrl.loads = 1'b0;
      ctrl.write = 1'b0;
    end
  end

endmodule

// File: rtl/datapath_fsm_ctrl.sv
// Simple RISC Machine datapath sequencer (Moore FSM).
// Optional illegal-opcode trap: DATAPATH_FSM_ILLEGAL_TRAP_EN.
module datapath_fsm_ctrl
  import datapath_fsm_ctrl_pkg::*;
#(
  parameter int STATE_W = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       asel,
  output logic       bsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       write,
  output logic       err
);

  logic [STATE_W-1:0] state_q;
  logic [4:0]         lop;
  state_t             st;
  state_t             st_n;
  ctrl_t              ctrl;

  assign st = state_t'(state_q);

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= S_WAIT;
    else
      state_q <= st_n;
  end

  // instruction is frozen for the whole sequence
  always_ff @(posedge clk) begin
    if (reset)
      lop <= '0;
    else if (st == S_WAIT && s)
      lop <= {opcode, op};
  end

  always_comb begin
    st_n = S_WAIT;
    case (st)
      S_WAIT:   st_n = s ? S_DECODE : S_WAIT;
      S_DECODE: begin
        if (is_mov_imm(lop))
          st_n = S_WR_IMM;
        else if (is_mov_reg(lop))
          st_n = S_GET_B;
        else if (is_alu(lop))
          st_n = S_GET_A;
        else
`ifdef DATAPATH_FSM_ILLEGAL_TRAP_EN
          st_n = S_ERR;
`else
          st_n = S_WAIT;
`endif
      end
      S_GET_A:  st_n = S_GET_B;
      S_GET_B:  st_n = S_EXEC;
      S_EXEC:   st_n = is_cmp(lop) ? S_WAIT : S_WR_REG;
      S_WR_REG: st_n = S_WAIT;
      S_WR_IMM: st_n = S_WAIT;
`ifdef DATAPATH_FSM_ILLEGAL_TRAP_EN
      S_ERR:    st_n = S_ERR;
`endif
      default:  st_n = S_WAIT;
    endcase
  end

  datapath_fsm_ctrl_outdec u_outdec (
    .st    (st),
    .lop   (lop),
    .reset (reset),
    .ctrl  (ctrl)
  );

  assign w     = ctrl.w;
  assign nsel  = ctrl.nsel;
  assign vsel  = ctrl.vsel;
  assign asel  = ctrl.asel;
  assign bsel  = ctrl.bsel;
  assign loada = ctrl.loada;
  assign loadb = ctrl.loadb;
  assign loadc = ctrl.loadc;
  assign loads = ctrl.loads;
  assign write = ctrl.write;
  assign err   = ctrl.err;

endmodule

// File: tb/tb_datapath_fsm_ctrl.sv
// Directed bench for datapath_fsm_ctrl.
// Trap expectations follow DATAPATH_FSM_ILLEGAL_TRAP_EN.
module tb_datapath_fsm_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w;
  logic [2:0] nsel;
  logic [1:0] vsel;
  logic       asel;
  logic       bsel;
  logic       loada;
  logic       loadb;
  logic       loadc;
  logic       loads;
  logic       write;
  logic       err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  datapath_fsm_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .s      (s),
    .opcode (opcode),
    .op     (op),
    .w      (w),
    .nsel   (nsel),
    .vsel   (vsel),
    .asel   (asel),
    .bsel   (bsel),
    .loada  (loada),
    .loadb  (loadb),
    .loadc  (loadc),
    .loads  (loads),
    .write  (write),
    .err    (err)
  );

  logic [13:0] obs;
  assign obs = {w, nsel, vsel, asel, bsel,
                loada, loadb, loadc, loads,
                write, err};

  // {w,nsel,vsel,asel,bsel,la,lb,lc,ls,wr,err}
  function automatic logic [13:0] ex(
    input logic       ew,
    input logic [2:0] en,
    input logic [1:0] ev,
    input logic       ea,
    input logic       la,
    input logic       lb,
    input logic       lc,
    input logic       ls,
    input logic       wr,
    input logic       ee
  );
    return {ew, en, ev, ea, 1'b0,
            la, lb, lc, ls, wr, ee};
  endfunction

  localparam logic [13:0] IDLE =
    {1'b1, 13'b0};
  localparam logic [13:0] BUSY = 14'b0;

  task automatic chk(input string tag,
                     input logic [13:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    s      = 1'b0;
    opcode = 3'b000;
    op     = 2'b00;

    // reset then idle
    step();
    chk("reset_edge", IDLE);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle", IDLE);
    end

    // MOV R3,#-7
    opcode = 3'b110; op = 2'b10; s = 1'b1;
    step();
    s = 1'b0;
    chk("movi_dec", BUSY);
    step();
    chk("movi_wr",
        ex(0, 3'b001, 2'b10, 0, 0, 0, 0, 0, 1, 0));
    step();
    chk("movi_done", IDLE);

    // ADD with opcode changed during GET_A
    opcode = 3'b101; op = 2'b00; s = 1'b1;
    step();
    s = 1'b0;
    chk("add_dec", BUSY);
    step();
    chk("add_geta",
        ex(0, 3'b001, 2'b00, 0, 1, 0, 0, 0, 0, 0));
    opcode = 3'b110; op = 2'b10;
    step();
    chk("add_getb",
        ex(0, 3'b100, 2'b00, 0, 0, 1, 0, 0, 0, 0));
    step();
    chk("add_exec",
        ex(0, 3'b000, 2'b00, 0, 0, 0, 1, 0, 0, 0));
    step();
    chk("add_wr",
        ex(0, 3'b010, 2'b00, 0, 0, 0, 0, 0, 1, 0));
    step();
    chk("add_done", IDLE);

    // MOV reg
    opcode = 3'b110; op = 2'b00; s = 1'b1;
    step();
    s = 1'b0;
    chk("movr_dec", BUSY);
    step();
    chk("movr_getb",
        ex(0, 3'b100, 2'b00, 0, 0, 1, 0, 0, 0, 0));
    step();
    chk("movr_exec",
        ex(0, 3'b000, 2'b00, 1, 0, 0, 1, 0, 0, 0));
    step();
    chk("movr_wr",
        ex(0, 3'b010, 2'b00, 0, 0, 0, 0, 0, 1, 0));
    step();
    chk("movr_done", IDLE);

    // CMP then MVN with s held high
    opcode = 3'b101; op = 2'b01; s = 1'b1;
    step();
    chk("cmp_dec", BUSY);
    step();
    chk("cmp_geta",
        ex(0, 3'b001, 2'b00, 0, 1, 0, 0, 0, 0, 0));
    step();
    chk("cmp_getb",
        ex(0, 3'b100, 2'b00, 0, 0, 1, 0, 0, 0, 0));
    step();
    chk("cmp_exec",
        ex(0, 3'b000, 2'b00, 0, 0, 0, 0, 1, 0, 0));
    op = 2'b11;
    step();
    chk("cmp_done", IDLE);
    step();
    s = 1'b0;
    chk("mvn_dec", BUSY);
    step();
    chk("mvn_geta",
        ex(0, 3'b001, 2'b00, 0, 1, 0, 0, 0, 0, 0));
    step();
    chk("mvn_getb",
        ex(0, 3'b100, 2'b00, 0, 0, 1, 0, 0, 0, 0));
    step();
    chk("mvn_exec",
        ex(0, 3'b000, 2'b00, 1, 0, 0, 1, 0, 0, 0));
    step();
    chk("mvn_wr",
        ex(0, 3'b010, 2'b00, 0, 0, 0, 0, 0, 1, 0));
    step();
    chk("mvn_done", IDLE);

    // reset in the WR_REG cycle of an AND
    opcode = 3'b101; op = 2'b10; s = 1'b1;
    step();
    s = 1'b0;
    step();
    step();
    step();
    step();
    chk("and_wr",
        ex(0, 3'b010, 2'b00, 0, 0, 0, 0, 0, 1, 0));
    reset = 1'b1;
    #1;
    chk("rst_gate",
        ex(0, 3'b010, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    step();
    reset = 1'b0;
    chk("rst_wait", IDLE);
    step();
    chk("rst_nowb", IDLE);

    // undefined opcode
    opcode = 3'b111; op = 2'b00; s = 1'b1;
    step();
    s = 1'b0;
    chk("ill_dec", BUSY);
`ifdef DATAPATH_FSM_ILLEGAL_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ill_trap",
          ex(0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 1));
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("ill_reset", IDLE);
`else
    step();
    chk("ill_nop", IDLE);
    step();
    chk("ill_idle", IDLE);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
